// File: rtl/quotient_bcd_formatter.sv
// quotient_bcd_formatter: exact Q6.4 quotient to packed BCD DD.dddd via sequential double-dabble
module quotient_bcd_formatter #(
  parameter int INT_W  = 6,
  parameter int FRAC_W = 4,
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    sclr,
  input  logic [INT_W+FRAC_W-1:0] q_in,
  input  logic                    valid_in,
  input  logic                    dvz_in,
  input  logic                    ovf_in,
  output logic [4*DIGITS-1:0]     bcd_out,
  output logic [1:0]              err_out,
  output logic                    busy,
  output logic                    done,
  output logic                    lost
);
  localparam int CW = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] P10 = BIN_W'(10**FRAC_W);
  localparam logic [BIN_W-1:0] P5  = BIN_W'(5**FRAC_W);
  typedef enum logic {IDLE, CONV} state_t;
  state_t state, state_nx;
  logic [BIN_W-1:0]    sh, sh_nx, scaled;
  logic [4*DIGITS-1:0] dig, dig_nx, adj;
  logic [CW-1:0]       cnt;
  logic                valid_d, cap, err, last;
  // fraction weight 5^FRAC_W makes the decimal scaling exact
  assign scaled = BIN_W'(q_in[INT_W+FRAC_W-1:FRAC_W]) * P10 + BIN_W'(q_in[FRAC_W-1:0]) * P5;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i+:4] = dig[4*i+:4] >= 4'd5 ? dig[4*i+:4] + 4'd3 : dig[4*i+:4];
  end
  assign {dig_nx, sh_nx} = {adj[4*DIGITS-2:0], sh, 1'b0};
  assign busy = state == CONV;
  always_comb begin
    cap = valid_in & ~valid_d;
    err = dvz_in | ovf_in;
    last = cnt == CW'(BIN_W-1);
    state_nx = state == IDLE ? (cap && !err ? CONV : IDLE) : (last ? IDLE : CONV);
  end
  always_ff @(posedge clk or posedge sclr)
    if (sclr) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      valid_d <= 1'b1;
      sh <= '0;
      dig <= '0;
      cnt <= '0;
      bcd_out <= '0;
      err_out <= '0;
      done <= 1'b0;
      lost <= 1'b0;
    end else begin
      valid_d <= valid_in;
      done <= 1'b0;
      lost <= 1'b0;
      if (state == IDLE) begin
        if (cap && err) begin
          bcd_out <= {DIGITS{4'hE}};
          err_out <= {ovf_in, dvz_in};
          done <= 1'b1;
        end else if (cap) begin
          sh <= scaled;
          dig <= '0;
          cnt <= '0;
        end
      end else begin
        sh <= sh_nx;
        dig <= dig_nx;
        cnt <= cnt + CW'(1);
        lost <= cap;
        if (last) begin
          bcd_out <= dig_nx;
          err_out <= 2'b00;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_quotient_bcd_formatter.sv
// tb_quotient_bcd_formatter: directed vector table plus multi-cycle corner sequences
module tb_quotient_bcd_formatter;
  logic        clk = 0, sclr = 1, valid_in = 0, dvz_in = 0, ovf_in = 0;
  logic [9:0]  q_in = '0;
  logic [23:0] bcd_out;
  logic [1:0]  err_out;
  logic        busy, done, lost;
  int checks = 0, errors = 0;
  quotient_bcd_formatter dut (
    .clk(clk), .sclr(sclr), .q_in(q_in), .valid_in(valid_in), .dvz_in(dvz_in),
    .ovf_in(ovf_in), .bcd_out(bcd_out), .err_out(err_out), .busy(busy),
    .done(done), .lost(lost)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [9:0]  q;
    logic        dvz;
    logic        ovf;
    logic [23:0] bcd;
    logic [1:0]  err;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < 40);
  endtask
  initial begin
    int n, dcnt, lcnt, bcnt;
    vecs[0] = '{10'b1000001000, 0, 0, 24'h325000, 2'b00};
    vecs[1] = '{10'b1010101010, 0, 0, 24'h426250, 2'b00};
    vecs[2] = '{10'h3FF,        0, 0, 24'h639375, 2'b00};
    vecs[3] = '{10'h000,        0, 0, 24'h000000, 2'b00};
    vecs[4] = '{10'h123,        1, 0, 24'hEEEEEE, 2'b01};
    vecs[5] = '{10'h011,        0, 0, 24'h010625, 2'b00};
    vecs[6] = '{10'h055,        0, 1, 24'hEEEEEE, 2'b10};
    vecs[7] = '{10'h3F0,        0, 0, 24'h630000, 2'b00};
    vecs[8] = '{10'h2AA,        1, 1, 24'hEEEEEE, 2'b11};
    step();
    step();
    chk("reset_bcd", 32'(bcd_out), 0);
    chk("reset_flags", {27'd0, err_out, busy, done, lost}, 0);
    @(negedge clk) sclr = 0;
    step();
    for (int i = 0; i < 9; i++) begin
      q_in = vecs[i].q;
      dvz_in = vecs[i].dvz;
      ovf_in = vecs[i].ovf;
      valid_in = 1;
      step();
      valid_in = 0;
      dvz_in = 0;
      ovf_in = 0;
      if (vecs[i].dvz | vecs[i].ovf) begin
        chk($sformatf("v%0d_err_done", i), {30'd0, done, busy}, 32'b10);
        n = 0;
      end else begin
        chk($sformatf("v%0d_busy", i), 32'(busy), 1);
        wait_done(n);
        chk($sformatf("v%0d_latency", i), n, 20);
      end
      chk($sformatf("v%0d_bcd", i), 32'(bcd_out), 32'(vecs[i].bcd));
      chk($sformatf("v%0d_err", i), 32'(err_out), 32'(vecs[i].err));
      step();
      chk($sformatf("v%0d_pulse", i), {30'd0, done, busy}, 0);
    end
    // second edge while busy is dropped
    q_in = 10'b1000001000;
    valid_in = 1;
    step();
    valid_in = 0;
    dcnt = 0;
    lcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 4) begin
        q_in = 10'h3FF;
        valid_in = 1;
      end else if (c == 5) valid_in = 0;
      step();
      dcnt += int'(done);
      lcnt += int'(lost);
      if (c == 4) chk("lost_pulse", 32'(lost), 1);
    end
    chk("lost_count", lcnt, 1);
    chk("lost_done_count", dcnt, 1);
    chk("lost_bcd", 32'(bcd_out), 32'h325000);
    // level valid gives exactly one capture
    q_in = 10'h011;
    valid_in = 1;
    dcnt = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      dcnt += int'(done);
    end
    chk("level_done_count", dcnt, 1);
    chk("level_bcd", 32'(bcd_out), 32'h010625);
    valid_in = 0;
    step();
    q_in = 10'h3F0;
    valid_in = 1;
    step();
    valid_in = 0;
    wait_done(n);
    chk("rearm_latency", n, 20);
    chk("rearm_bcd", 32'(bcd_out), 32'h630000);
    // async reset mid-conversion, valid left high
    q_in = 10'h3FF;
    valid_in = 1;
    step();
    for (int c = 0; c < 9; c++) step();
    chk("pre_reset_busy", 32'(busy), 1);
    #2 sclr = 1;
    #1;
    chk("abort_bcd", 32'(bcd_out), 0);
    chk("abort_flags", {27'd0, err_out, busy, done, lost}, 0);
    @(negedge clk) sclr = 0;
    dcnt = 0;
    bcnt = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      dcnt += int'(done);
      bcnt += int'(busy);
    end
    chk("post_reset_no_capture", dcnt + bcnt, 0);
    chk("post_reset_bcd", 32'(bcd_out), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
